// File: rtl/game_flow_ctrl.sv
// Game flow controller: turns keys, game-logic events and frame ticks into the
// game state, lives count and one-cycle game_rst / state_chg pulses.
module game_flow_ctrl #(
   parameter int NUM_KEYS       = 4,
   parameter int LIVES          = 3,
   parameter int LIVES_W        = 2,
   parameter int RESPAWN_FRAMES = 60,
   parameter int RESULT_FRAMES  = 300,
   parameter int CNT_W          = 9
) (
   input  logic                vga_clk,
   input  logic                sys_rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   input  logic                key_pause,
   input  logic                frame_tick,
   input  logic                game_won,
   input  logic                game_hit,
   output logic [2:0]          state,
   output logic [LIVES_W-1:0]  lives,
   output logic                game_rst,
   output logic                state_chg
);

   typedef enum logic [2:0] {
      ST_START   = 3'b000,
      ST_PLAY    = 3'b001,
      ST_PAUSE   = 3'b011,
      ST_RESPAWN = 3'b010,
      ST_WON     = 3'b110,
      ST_OVER    = 3'b100
   } state_e;

   localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);
   localparam logic [CNT_W-1:0]   RESULT_LAST  = CNT_W'(RESULT_FRAMES - 1);
   localparam bit                 RESULT_TO    = (RESULT_FRAMES != 0);
   localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);

   state_e               state_q, state_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 game_rst_q, game_rst_d;
   logic                 state_chg_q, state_chg_d;
   logic                 any_hist_q, pause_hist_q;
   logic                 any_press, pause_press;
   logic                 respawn_done, result_done;

   assign any_press    = (|key_in) & ~any_hist_q;
   assign pause_press  = key_pause & ~pause_hist_q;
   assign respawn_done = frame_tick && (cnt_q == RESPAWN_LAST);
   assign result_done  = RESULT_TO && frame_tick && (cnt_q == RESULT_LAST);

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      game_rst_d = 1'b0;
      case (state_q)
         ST_START: begin
            if (any_press) begin
               state_d    = ST_PLAY;
               lives_d    = LIVES_INIT;
               game_rst_d = 1'b1;
            end
         end
         ST_PLAY: begin
            // Win outranks a simultaneous hit, so no life is lost on the winning frame
            if (game_won) begin
               state_d = ST_WON;
            end else if (game_hit) begin
               if (lives_q <= LIVES_W'(1)) begin
                  state_d = ST_OVER;
                  lives_d = '0;
               end else begin
                  state_d = ST_RESPAWN;
                  lives_d = lives_q - LIVES_W'(1);
               end
            end else if (pause_press) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (pause_press) state_d = ST_PLAY;
         end
         ST_RESPAWN: begin
            if (respawn_done) state_d = ST_PLAY;
         end
         ST_WON, ST_OVER: begin
            if (any_press || result_done) state_d = ST_START;
         end
         default: begin
            state_d = ST_START;
         end
      endcase

      state_chg_d = (state_d != state_q);
      if (state_chg_d)
         cnt_d = '0;
      else if (frame_tick && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
   end

   // Key history resets high so a key held through reset does not register as a press
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_START;
         lives_q      <= LIVES_INIT;
         cnt_q        <= '0;
         game_rst_q   <= 1'b0;
         state_chg_q  <= 1'b0;
         any_hist_q   <= 1'b1;
         pause_hist_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         cnt_q        <= cnt_d;
         game_rst_q   <= game_rst_d;
         state_chg_q  <= state_chg_d;
         any_hist_q   <= |key_in;
         pause_hist_q <= key_pause;
      end
   end

   assign state     = state_q;
   assign lives     = lives_q;
   assign game_rst  = game_rst_q;
   assign state_chg = state_chg_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios then random traffic, scored
// cycle by cycle against a behavioural model of the game rules.
module tb_game_flow_ctrl;

   localparam int LV = 3;
   localparam int RF = 60;
   localparam int XF = 300;
   localparam logic [2:0] S_START = 3'b000, S_PLAY = 3'b001, S_PAUSE = 3'b011,
                          S_RESP  = 3'b010, S_WON  = 3'b110, S_OVER  = 3'b100;

   logic       vga_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [3:0] key_in = 4'b0000;
   logic       key_pause = 1'b0, frame_tick = 1'b0, game_won = 1'b0, game_hit = 1'b0;
   logic [2:0] state;
   logic [1:0] lives;
   logic       game_rst, state_chg;

   game_flow_ctrl #(
      .NUM_KEYS(4), .LIVES(LV), .LIVES_W(2), .RESPAWN_FRAMES(RF),
      .RESULT_FRAMES(XF), .CNT_W(9)
   ) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key_in(key_in), .key_pause(key_pause),
      .frame_tick(frame_tick), .game_won(game_won), .game_hit(game_hit),
      .state(state), .lives(lives), .game_rst(game_rst), .state_chg(state_chg)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] lv;
      logic       grst;
      logic       chg;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;

   // Reference model: current screen, lives left, frame ticks seen since entering the screen
   logic [2:0] m_st;
   int         m_lives;
   int         m_ticks;
   bit         m_pany, m_ppause;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
      end
   endtask

   task automatic model_step();
      bit         anyp, pp;
      logic [2:0] ns;
      int         nl;
      bit         g;
      anyp = (|key_in) && !m_pany;
      pp   = key_pause && !m_ppause;
      ns   = m_st;
      nl   = m_lives;
      g    = 1'b0;
      case (m_st)
         S_START: if (anyp) begin ns = S_PLAY; nl = LV; g = 1'b1; end
         S_PLAY: begin
            if (game_won) ns = S_WON;
            else if (game_hit) begin
               nl = m_lives - 1;
               ns = (nl == 0) ? S_OVER : S_RESP;
            end else if (pp) ns = S_PAUSE;
         end
         S_PAUSE: if (pp) ns = S_PLAY;
         S_RESP:  if (frame_tick && m_ticks == RF - 1) ns = S_PLAY;
         default: if (anyp || (frame_tick && m_ticks == XF - 1)) ns = S_START;
      endcase
      q.push_back('{st: ns, lv: nl[1:0], grst: g, chg: (ns != m_st)});
      if (ns != m_st) m_ticks = 0;
      else if (frame_tick && m_ticks < 511) m_ticks++;
      m_st     = ns;
      m_lives  = nl;
      m_pany   = |key_in;
      m_ppause = key_pause;
   endtask

   task automatic step(input logic [3:0] k, input logic p, input logic t,
                       input logic w, input logic h);
      key_in = k; key_pause = p; frame_tick = t; game_won = w; game_hit = h;
      model_step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] held);
      @(negedge vga_clk);
      #1;
      key_in = held; key_pause = 1'b0; frame_tick = 1'b0; game_won = 1'b0; game_hit = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      check("rst_state", state, S_START);
      check("rst_lives", lives, LV);
      check("rst_game_rst", game_rst, 0);
      check("rst_state_chg", state_chg, 0);
      q.delete();
      m_st = S_START; m_lives = LV; m_ticks = 0; m_pany = 1'b1; m_ppause = 1'b1;
      repeat (2) @(negedge vga_clk);
      #1;
      sys_rst_n = 1'b1;
   endtask

   always @(negedge vga_clk) begin
      if (sys_rst_n) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_underflow at %0t: got output with no expectation", $time);
         end else begin
            mon_e = q.pop_front();
            check("state", state, mon_e.st);
            check("lives", lives, mon_e.lv);
            check("game_rst", game_rst, mon_e.grst);
            check("state_chg", state_chg, mon_e.chg);
         end
      end
   end

   initial begin
      // Key held through reset is not a press; a later rising key starts the game
      do_reset(4'b0001);
      repeat (3) step(4'b0001, 0, 1, 0, 0);
      step(4'b0000, 0, 0, 0, 0);
      step(4'b0100, 0, 0, 0, 0);
      // Three hits spaced beyond the respawn delay
      repeat (2) begin
         step(4'b0000, 0, 0, 0, 1);
         repeat (65) step(4'b0000, 0, 1, 0, 0);
      end
      step(4'b0000, 0, 0, 0, 1);
      step(4'b1000, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 0);
      step(4'b0001, 0, 0, 0, 0);
      // Win and hit together
      step(4'b0000, 0, 0, 1, 1);
      repeat (305) step(4'b0000, 0, 1, 0, 0);
      step(4'b0010, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 1, 0);
      repeat (299) step(4'b0000, 0, 1, 0, 0);
      step(4'b0010, 0, 1, 0, 0);
      step(4'b0000, 0, 0, 0, 0);
      step(4'b0001, 0, 0, 0, 0);
      // Pause ignores keys and events
      step(4'b0000, 1, 0, 0, 0);
      step(4'b1111, 1, 1, 1, 1);
      step(4'b0000, 0, 1, 0, 1);
      step(4'b0000, 1, 0, 0, 0);
      // Reset mid-respawn, then confirm the respawn delay is full length again
      step(4'b0000, 0, 0, 0, 1);
      repeat (30) step(4'b0000, 0, 1, 0, 0);
      do_reset(4'b0000);
      step(4'b0100, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 1);
      repeat (62) step(4'b0000, 0, 1, 0, 0);
      // Random traffic
      repeat (4000) begin
         if ($urandom_range(0, 1499) == 0) do_reset(4'($urandom));
         step(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000,
              ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 24) == 0));
      end
      @(negedge vga_clk);
      #1;
      check("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
